// File: rtl/sample_iterator_if.sv
// Bus between the bounding-box stage, the sample iterator and the sample test stage.
// The master drives the triangle, box and mode; the slave returns halt and the samples.
interface sample_iterator_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) ();
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                   validTri_R13H;
    logic [3:0]                             subSample_RnnnnU;
    logic                                   halt_RnnnnH;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic [1:0][SIGFIG-1:0]                 sample_R14S;
    logic                                   validSamp_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        input  halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        output halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );
endinterface

// File: rtl/sample_iterator.sv
// Sample iterator: walks one triangle's bounding box in raster order (x fastest,
// then y ascending), emitting one sample location per cycle with the latched
// triangle and color. Upstream is held off via halt while a box is being walked.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic              clk,
    input  logic              rst,
    sample_iterator_if.slave  bus
);

    typedef enum logic [0:0] {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_t;

    // Grid spacing for the MSAA mode; anything that is not one-hot walks at 1x.
    function automatic logic [SIGFIG-1:0] step_for(input logic [3:0] mode);
        logic [SIGFIG-1:0] one;
        one = {{(SIGFIG-1){1'b0}}, 1'b1};
        case (mode)
            4'b1000: step_for = one << RADIX;
            4'b0100: step_for = one << (RADIX - 1);
            4'b0010: step_for = one << (RADIX - 2);
            4'b0001: step_for = one << (RADIX - 3);
            default: step_for = one << RADIX;
        endcase
    endfunction

    state_t                                 r_state;
    state_t                                 w_state_nxt;
    logic                                   r_valid;
    logic                                   w_valid_nxt;
    logic [1:0][SIGFIG-1:0]                 r_sample;
    logic [1:0][SIGFIG-1:0]                 w_sample_nxt;
    logic                                   w_load;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
    logic [COLORS-1:0][SIGFIG-1:0]          r_color;
    logic [SIGFIG-1:0]                      r_ll_x;
    logic [SIGFIG-1:0]                      r_ur_x;
    logic [SIGFIG-1:0]                      r_ur_y;
    logic [SIGFIG-1:0]                      r_step;

    // Next-state and next-sample logic: accept in WAIT, raster-step in TEST.
    always_comb begin
        w_state_nxt  = r_state;
        w_valid_nxt  = r_valid;
        w_sample_nxt = r_sample;
        w_load       = 1'b0;
        case (r_state)
            WAIT: begin
                if (bus.validTri_R13H) begin
                    w_load          = 1'b1;
                    w_state_nxt     = TEST;
                    w_valid_nxt     = 1'b1;
                    w_sample_nxt[0] = bus.box_R13S[0][0];
                    w_sample_nxt[1] = bus.box_R13S[0][1];
                end else begin
                    w_valid_nxt = 1'b0;
                end
            end
            TEST: begin
                // Termination is exact equality with the upper-right corner only.
                if (r_sample[0] != r_ur_x) begin
                    w_sample_nxt[0] = r_sample[0] + r_step;
                end else if (r_sample[1] != r_ur_y) begin
                    w_sample_nxt[0] = r_ll_x;
                    w_sample_nxt[1] = r_sample[1] + r_step;
                end else begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = WAIT;
                end
            end
            default: begin
                w_state_nxt = WAIT;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, sample and latched-triangle registers; reset aborts any walk in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= WAIT;
            r_valid  <= 1'b0;
            r_sample <= '0;
            r_tri    <= '0;
            r_color  <= '0;
            r_ll_x   <= '0;
            r_ur_x   <= '0;
            r_ur_y   <= '0;
            r_step   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_valid  <= w_valid_nxt;
            r_sample <= w_sample_nxt;
            if (w_load) begin
                r_tri   <= bus.tri_R13S;
                r_color <= bus.color_R13U;
                r_ll_x  <= bus.box_R13S[0][0];
                r_ur_x  <= bus.box_R13S[1][0];
                r_ur_y  <= bus.box_R13S[1][1];
                r_step  <= step_for(bus.subSample_RnnnnU);
            end
        end
    end

    assign bus.halt_RnnnnH    = (r_state == TEST);
    assign bus.validSamp_R14H = r_valid;
    assign bus.sample_R14S    = r_sample;
    assign bus.tri_R14S       = r_tri;
    assign bus.color_R14U     = r_color;

endmodule

// File: tb/tb_sample_iterator.sv
// Testbench for sample_iterator: directed scenarios plus randomized triangles,
// checked against a raster-order sample list built from the box and step.
module tb_sample_iterator;

    typedef logic [2:0][2:0][23:0] tri_t;
    typedef logic [2:0][23:0]      col_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sample_iterator_if bus ();

    sample_iterator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(input logic [3:0] mode);
        if (mode == 4'b1000) return 1024;
        if (mode == 4'b0100) return 512;
        if (mode == 4'b0010) return 256;
        if (mode == 4'b0001) return 128;
        return 1024;
    endfunction

    function automatic tri_t rand_tri();
        tri_t t;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                t[v][a] = 24'($urandom);
        return t;
    endfunction

    function automatic col_t rand_col();
        col_t c;
        for (int i = 0; i < 3; i++) c[i] = 24'($urandom);
        return c;
    endfunction

    task automatic drive(input tri_t t, input col_t c, input int llx, input int lly,
                         input int urx, input int ury, input logic [3:0] mode, input logic v);
        bus.tri_R13S         = t;
        bus.color_R13U       = c;
        bus.box_R13S[0][0]   = 24'(llx);
        bus.box_R13S[0][1]   = 24'(lly);
        bus.box_R13S[1][0]   = 24'(urx);
        bus.box_R13S[1][1]   = 24'(ury);
        bus.subSample_RnnnnU = mode;
        bus.validTri_R13H    = v;
    endtask

    // Observes samples from the current point (first sample visible) until validSamp drops.
    task automatic collect(input string name, input int llx, input int lly, input int urx,
                           input int ury, input int step, input tri_t t, input col_t c,
                           input logic drop_valid);
        int ex[$];
        int ey[$];
        int n;
        logic [47:0] got;
        logic [47:0] want;
        for (int y = lly; y <= ury; y += step)
            for (int x = llx; x <= urx; x += step) begin
                ex.push_back(x);
                ey.push_back(y);
            end
        n = 0;
        while (bus.validSamp_R14H === 1'b1 && n < 200) begin
            if (drop_valid) bus.validTri_R13H = 1'b0;
            checks++;
            got = {bus.sample_R14S[0], bus.sample_R14S[1]};
            if (n < ex.size()) begin
                want = {24'(ex[n]), 24'(ey[n])};
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s sample %0d: got %h required %h", name, n, got, want);
                end
            end else begin
                errors++;
                $display("FAIL %s extra sample %0d: got %h required none", name, n, got);
            end
            checks++;
            if (bus.tri_R14S !== t || bus.color_R14U !== c || bus.halt_RnnnnH !== 1'b1) begin
                errors++;
                $display("FAIL %s tri/color/halt at sample %0d: halt %b required 1", name, n,
                         bus.halt_RnnnnH);
            end
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != ex.size()) begin
            errors++;
            $display("FAIL %s sample count: got %0d required %0d", name, n, ex.size());
        end
        checks++;
        if (bus.halt_RnnnnH !== 1'b0) begin
            errors++;
            $display("FAIL %s halt after walk: got %b required 0", name, bus.halt_RnnnnH);
        end
    endtask

    task automatic run_tri(input string name, input int llx, input int lly, input int urx,
                           input int ury, input logic [3:0] mode);
        tri_t t;
        col_t c;
        t = rand_tri();
        c = rand_col();
        drive(t, c, llx, lly, urx, ury, mode, 1'b1);
        @(posedge clk); #1;
        collect(name, llx, lly, urx, ury, step_of(mode), t, c, 1'b1);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.validSamp_R14H !== 1'b0 || bus.halt_RnnnnH !== 1'b0 ||
            bus.sample_R14S !== '0 || bus.tri_R14S !== '0 || bus.color_R14U !== '0) begin
            errors++;
            $display("FAIL %s: valid %b halt %b sample %h required all zero", name,
                     bus.validSamp_R14H, bus.halt_RnnnnH, bus.sample_R14S);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive('0, '0, 0, 0, 0, 0, 4'b1000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;
        drive(rand_tri(), rand_col(), 0, 0, 2048, 2048, 4'b1000, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (bus.validSamp_R14H !== 1'b1) begin
            errors++;
            $display("FAIL accept_before_reset: got %b required 1", bus.validSamp_R14H);
        end
        #2 rst = 1'b1;
        #1;
        check_zero("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        bus.validTri_R13H = 1'b0;
        @(posedge clk); #1;
        check_zero("after_reset_release");
    endtask

    task automatic test_1x();
        run_tri("walk_1x", 0, 0, 'h800, 'h800, 4'b1000);
    endtask

    task automatic test_4x();
        run_tri("walk_4x", -'h200, 0, 'h200, 'h200, 4'b0100);
    endtask

    task automatic test_degenerate();
        run_tri("degenerate", 'h1400, 'hC00, 'h1400, 'hC00, 4'b1000);
    endtask

    task automatic test_back_to_back();
        tri_t ta, tb;
        col_t ca, cb;
        ta = rand_tri(); ca = rand_col();
        tb = rand_tri(); cb = rand_col();
        drive(ta, ca, 0, 0, 'h400, 'h400, 4'b1000, 1'b1);
        @(posedge clk); #1;
        collect("b2b_A", 0, 0, 'h400, 'h400, 1024, ta, ca, 1'b0);
        checks++;
        if (bus.validSamp_R14H !== 1'b0 || bus.tri_R14S !== ta || bus.color_R14U !== ca) begin
            errors++;
            $display("FAIL b2b_bubble: valid %b required 0, tri held %b required 1",
                     bus.validSamp_R14H, bus.tri_R14S === ta);
        end
        drive(tb, cb, 'h800, -'h400, 'hC00, 0, 4'b1000, 1'b1);
        @(posedge clk); #1;
        collect("b2b_B", 'h800, -'h400, 'hC00, 0, 1024, tb, cb, 1'b1);
    endtask

    task automatic test_reset_midwalk();
        drive(rand_tri(), rand_col(), 0, 0, 'h800, 'h800, 4'b1000, 1'b1);
        @(posedge clk); #1;
        bus.validTri_R13H = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.validSamp_R14H !== 1'b1 || bus.sample_R14S[0] !== 24'h800) begin
            errors++;
            $display("FAIL midwalk_sample3: got %h required 000800", bus.sample_R14S[0]);
        end
        #2 rst = 1'b1;
        #1;
        check_zero("midwalk_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.validSamp_R14H !== 1'b0 || bus.halt_RnnnnH !== 1'b0) begin
                errors++;
                $display("FAIL midwalk_dropped cycle %0d: valid %b required 0", i,
                         bus.validSamp_R14H);
            end
        end
        run_tri("after_midwalk", -'h400, -'h400, 0, 0, 4'b1000);
    endtask

    task automatic test_random();
        logic [3:0] modes [8];
        logic [3:0] m;
        int s, llx, lly;
        modes = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b1100, 4'b1111, 4'b0011};
        for (int k = 0; k < 24; k++) begin
            m   = modes[$urandom_range(0, 7)];
            s   = step_of(m);
            llx = (int'($urandom_range(0, 40)) - 20) * s;
            lly = (int'($urandom_range(0, 40)) - 20) * s;
            run_tri($sformatf("random%0d", k), llx, lly,
                    llx + int'($urandom_range(0, 3)) * s,
                    lly + int'($urandom_range(0, 3)) * s, m);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_1x();
        test_4x();
        test_degenerate();
        test_back_to_back();
        test_reset_midwalk();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
